// File: rtl/custom_axi_result_fifo.sv
// Result collector: filters core completions, queues valid results in a small FIFO and
// presents them on a valid/ready port, with sticky overflow and malformed-strobe flags.
module custom_axi_result_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DATA_WIDTH:0]         res_i,
  input  logic [1:0]                  res_en_i,
  input  logic                        clear_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [DATA_WIDTH-1:0]       m_data_o,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        overflow_o,
  output logic                        malformed_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  malformed_q, malformed_d;

  logic push_req, bad_strobe, pop, full, do_push;

  always_comb begin
    push_req   = (res_en_i == 2'b01) && res_i[0];
    bad_strobe = (res_en_i != 2'b00) && !push_req;
    pop        = (level_q != '0) && m_ready_i;
    full       = (level_q == FullLvl);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    do_push    = push_req && (!full || pop);

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    malformed_d = malformed_q;

    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      malformed_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = res_i[DATA_WIDTH:1];
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !pop) begin
        level_d = level_q + LvlW'(1);
      end else if (pop && !do_push) begin
        level_d = level_q - LvlW'(1);
      end
      if (push_req && !do_push) begin
        overflow_d = 1'b1;
      end
      if (bad_strobe) begin
        malformed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      malformed_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      malformed_q <= malformed_d;
    end
  end

  assign m_valid_o   = (level_q != '0);
  assign m_data_o    = m_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign malformed_o = malformed_q;

endmodule

// File: tb/tb_custom_axi_result_fifo.sv
// Bench for custom_axi_result_fifo: directed vector table, hand-written wrap and async-reset
// sequences, then random traffic against a queue-based reference model.
module tb_custom_axi_result_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] res;
  logic [1:0]  res_en;
  logic        clear;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [2:0]  level;
  logic        overflow;
  logic        malformed;

  int errors = 0;
  int checks = 0;

  custom_axi_result_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .res_i       (res),
    .res_en_i    (res_en),
    .clear_i     (clear),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .level_o     (level),
    .overflow_o  (overflow),
    .malformed_o (malformed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] res;
    logic [1:0]  en;
    logic        clr;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  el;
    logic        eo;
    logic        em;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] pr(input int n);
    logic [15:0] v;
    v = n[15:0];
    return {v, 1'b1};
  endfunction

  function automatic vec_t mk(input string name, input logic [16:0] r, input logic [1:0] en,
                              input logic clr, input logic rdy, input logic ev,
                              input logic [15:0] ed, input logic [2:0] el, input logic eo,
                              input logic em);
    vec_t v;
    v.name = name; v.res = r; v.en = en; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo; v.em = em;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic ev, input logic [15:0] ed,
                           input logic [2:0] el, input logic eo, input logic em);
    check({name, ".valid"}, int'(m_valid), int'(ev));
    check({name, ".data"}, int'(m_data), int'(ed));
    check({name, ".level"}, int'(level), int'(el));
    check({name, ".ovf"}, int'(overflow), int'(eo));
    check({name, ".mal"}, int'(malformed), int'(em));
  endtask

  // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic [16:0] r, input logic [1:0] en, input logic clr,
                      input logic rdy);
    @(negedge clk);
    res = r; res_en = en; clear = clr; m_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] model_q[$];
  logic        model_ovf;
  logic        model_mal;

  initial begin
    rst_n = 1'b0; res = '0; res_en = '0; clear = 1'b0; m_ready = 1'b0;
    #1;
    check_all("reset", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // name, res, en, clr, rdy -> valid, data, level, ovf, mal
    vecs.push_back(mk("push55e6", 17'h0ABCD, 2'b01, 0, 0, 1, 16'h55E6, 1, 0, 0));
    vecs.push_back(mk("pop55e6",  17'h0,     2'b00, 0, 1, 0, 16'h0,    0, 0, 0));
    vecs.push_back(mk("rdy_empty", 17'h0,    2'b00, 0, 1, 0, 16'h0,    0, 0, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk("fill", pr(i), 2'b01, 0, 0, 1, 16'd1, 3'(i), 0, 0));
    vecs.push_back(mk("overflow", pr(5), 2'b01, 0, 0, 1, 16'd1, 4, 1, 0));
    vecs.push_back(mk("drain1", 17'h0, 2'b00, 0, 1, 1, 16'd2, 3, 1, 0));
    vecs.push_back(mk("drain2", 17'h0, 2'b00, 0, 1, 1, 16'd3, 2, 1, 0));
    vecs.push_back(mk("drain3", 17'h0, 2'b00, 0, 1, 1, 16'd4, 1, 1, 0));
    vecs.push_back(mk("drain4", 17'h0, 2'b00, 0, 1, 0, 16'h0, 0, 1, 0));
    vecs.push_back(mk("clr_ovf", 17'h0, 2'b00, 1, 0, 0, 16'h0, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk("refill", pr(i), 2'b01, 0, 0, 1, 16'd1, 3'(i), 0, 0));
    vecs.push_back(mk("full_pushpop", pr(9), 2'b01, 0, 1, 1, 16'd2, 4, 0, 0));
    vecs.push_back(mk("fdrain1", 17'h0, 2'b00, 0, 1, 1, 16'd3, 3, 0, 0));
    vecs.push_back(mk("fdrain2", 17'h0, 2'b00, 0, 1, 1, 16'd4, 2, 0, 0));
    vecs.push_back(mk("fdrain3", 17'h0, 2'b00, 0, 1, 1, 16'd9, 1, 0, 0));
    vecs.push_back(mk("fdrain4", 17'h0, 2'b00, 0, 1, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk("mal_en10", pr(7), 2'b10, 0, 0, 0, 16'h0, 0, 0, 1));
    vecs.push_back(mk("mal_clr1", 17'h0, 2'b00, 1, 0, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk("mal_bit0", 17'h02468, 2'b01, 0, 0, 0, 16'h0, 0, 0, 1));
    vecs.push_back(mk("mal_clr2", 17'h0, 2'b00, 1, 0, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk("mal_en11", pr(3), 2'b11, 0, 0, 0, 16'h0, 0, 0, 1));
    vecs.push_back(mk("clr_vs_push", pr(6), 2'b01, 1, 0, 0, 16'h0, 0, 0, 0));
    vecs.push_back(mk("clr_vs_mal", 17'h0, 2'b10, 1, 0, 0, 16'h0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].res, vecs[i].en, vecs[i].clr, vecs[i].rdy);
      check_all(vecs[i].name, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eo, vecs[i].em);
    end

    // Pointer wrap: push 0x100+i while popping the previous value.
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) check("wrap.head", int'(m_data), 32'h100 + i - 1);
      if (i < 10) step(pr(32'h100 + i), 2'b01, 1'b0, i > 0);
      else        step(17'h0, 2'b00, 1'b0, 1'b1);
      if (i < 10) check_all("wrap", 1'b1, 16'(32'h100 + i), 3'd1, 1'b0, 1'b0);
      else        check_all("wrap_end", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    end

    // Async reset between edges with three entries queued.
    for (int i = 1; i <= 3; i++) step(pr(32'h20 + i), 2'b01, 1'b0, 1'b0);
    check("pre_rst.level", int'(level), 3);
    @(negedge clk);
    res_en = 2'b00;
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    step(pr(7), 2'b01, 1'b0, 1'b0);
    check_all("post_rst_push", 1'b1, 16'h7, 3'd1, 1'b0, 1'b0);
    step(17'h0, 2'b00, 1'b0, 1'b1);
    check_all("post_rst_pop", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);

    // Random traffic against a queue model.
    model_q.delete();
    model_ovf = 1'b0;
    model_mal = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [16:0] r;
      logic [1:0]  en;
      logic        clr, rdy, push, bad;
      int          sel;
      r   = 17'($urandom);
      sel = $urandom_range(0, 19);
      en  = (sel < 12) ? 2'b01 : (sel < 17) ? 2'b00 : 2'($urandom_range(1, 3));
      if (sel < 11) r[0] = 1'b1;
      clr = ($urandom_range(0, 49) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      push = (en == 2'b01) && r[0];
      bad  = (en != 2'b00) && !push;
      if (clr) begin
        model_q.delete();
        model_ovf = 1'b0;
        model_mal = 1'b0;
      end else begin
        if (rdy && model_q.size() != 0) void'(model_q.pop_front());
        if (push) begin
          if (model_q.size() < DEPTH) model_q.push_back(r[16:1]);
          else model_ovf = 1'b1;
        end
        if (bad) model_mal = 1'b1;
      end
      step(r, en, clr, rdy);
      check_all("rand", model_q.size() != 0,
                (model_q.size() != 0) ? model_q[0] : 16'h0,
                3'(model_q.size()), model_ovf, model_mal);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
